wb_regfile: RTL

//   Write-back stage and general-purpose register file of the 5-stage pipeline.
//   - Consumes the registered MEM/WB outputs.
//   - Selects the write-back result (load data vs ALU result) and commits it to a
//     32-entry register file.
//   - Serves the two decode-stage read ports with same-cycle write-through bypass.
//   - Counts committed register writes for performance and debug.

---
 rtl/wb_regfile.sv | 104 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and general-purpose register file.
//
// Selects the write-back value (load data or ALU result), commits it to a
// register file of NREGS entries, serves two asynchronous decode read ports
// with write-first bypass, and counts effective commits since reset.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   Regfile_weW     write-back enable from MEM/WB
//   memToRegW       1: commit readDataW, 0: commit aluOutW
//   aluOutW         ALU result from MEM/WB
//   readDataW       load data from MEM/WB
//   writeRegAddrW   destination register
//   rsAddrD/rtAddrD decode read port A/B addresses
//   rsDataD/rtDataD decode read port A/B data (combinational)
//   resultW         selected write-back value (combinational), for forwarding
//   wbCount         number of effective commits since reset (wraps)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Regfile_weW,
  input  logic              memToRegW,
  input  logic [DATA_W-1:0] aluOutW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [ADDR_W-1:0] writeRegAddrW,
  input  logic [ADDR_W-1:0] rsAddrD,
  input  logic [ADDR_W-1:0] rtAddrD,
  output logic [DATA_W-1:0] rsDataD,
  output logic [DATA_W-1:0] rtDataD,
  output logic [DATA_W-1:0] resultW,
  output logic [CNT_W-1:0]  wbCount
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              we_eff;

  // Write-back mux.
  always_comb begin
    resultW = memToRegW ? readDataW : aluOutW;
  end

  // A write only takes effect outside reset and never to r0; the same
  // qualifier gates the bypass so reset-cycle reads see stored contents.
  always_comb begin
    we_eff = Regfile_weW && !rst && (writeRegAddrW != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (we_eff) begin
      regs_d[writeRegAddrW] = resultW;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (we_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    cnt_q  <= cnt_d;
  end

  // Read ports: r0 is hard zero, then write-first bypass, then storage.
  always_comb begin
    rsDataD = regs_q[rsAddrD];
    if (rsAddrD == '0) begin
      rsDataD = '0;
    end else if (we_eff && (writeRegAddrW == rsAddrD)) begin
      rsDataD = resultW;
    end
  end

  always_comb begin
    rtDataD = regs_q[rtAddrD];
    if (rtAddrD == '0) begin
      rtDataD = '0;
    end else if (we_eff && (writeRegAddrW == rtAddrD)) begin
      rtDataD = resultW;
    end
  end

  always_comb begin
    wbCount = cnt_q;
  end

endmodule
